// File: rtl/carry_select_seq_adder_ctrl_pkg.sv
// seq_add_pkg: shared types and constants for the sequential carry-select adder.
// Holds the controller state encoding, the default operand/slice widths, and
// a helper that sizes the slice index register.
package seq_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_add_state_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_SLICE = 8;

   // Bits needed to count NSLICE slices; a single-slice build still gets one bit.
   function automatic int idx_width(input int n);
      if (n <= 1) begin
         return 1;
      end
      return $clog2(n);
   endfunction

endpackage

// File: rtl/carry_select_seq_adder_ctrl_if.sv
// carry_select_seq_adder_ctrl_if: operand/result handshake bundle for the
// sequential carry-select adder. The slave modport is the controller view,
// the master modport is the producer/consumer view.
// Optional macro SEQ_ADD_OVF_EN adds the signed-overflow flag ovf.
interface carry_select_seq_adder_ctrl_if
   import seq_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef SEQ_ADD_OVF_EN
   logic             ovf;
`endif

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  cin,
      input  out_ready,
      output in_ready,
      output out_valid,
      output sum,
      output cout,
`ifdef SEQ_ADD_OVF_EN
      output ovf,
`endif
      output busy
   );

   modport master (
      output in_valid,
      output a,
      output b,
      output cin,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  sum,
      input  cout,
`ifdef SEQ_ADD_OVF_EN
      input  ovf,
`endif
      input  busy
   );

endinterface

// File: rtl/carry_select_seq_adder_ctrl_cond_sum_slice.sv
// cond_sum_slice: combinational conditional-sum cell, SLICE bits wide.
// Produces the slice sum and carry-out for both possible carry-in values so
// the controller only has to pick one pair with its running carry.
module cond_sum_slice #(
   parameter int SLICE = 8
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   output logic [SLICE-1:0] s0,
   output logic [SLICE-1:0] s1,
   output logic             c0,
   output logic             c1
);

   logic [SLICE:0] sum_c0;
   logic [SLICE:0] sum_c1;

   // Both candidate results, one extra bit wide to capture the carry-out.
   always_comb begin
      sum_c0 = {1'b0, a} + {1'b0, b};
      sum_c1 = {1'b0, a} + {1'b0, b} + (SLICE+1)'(1);
   end

   assign s0 = sum_c0[SLICE-1:0];
   assign c0 = sum_c0[SLICE];
   assign s1 = sum_c1[SLICE-1:0];
   assign c1 = sum_c1[SLICE];

endmodule

// File: rtl/carry_select_seq_adder_ctrl.sv
// carry_select_seq_adder_ctrl: multi-cycle adder that walks WIDTH-bit operands
// SLICE bits per cycle through one cond_sum_slice, choosing each slice result
// with a registered running carry. Valid/ready handshakes on both sides.
// Optional macro SEQ_ADD_OVF_EN adds a registered signed-overflow flag ovf.
module carry_select_seq_adder_ctrl
   import seq_add_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SLICE = DEFAULT_SLICE
) (
   input  logic                          clk,
   input  logic                          rst,
   carry_select_seq_adder_ctrl_if.slave  bus
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = idx_width(NSLICE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   if ((SLICE < 1) || ((WIDTH % SLICE) != 0)) begin : g_bad_cfg
      $error("carry_select_seq_adder_ctrl: WIDTH (%0d) must be a multiple of SLICE (%0d)",
             WIDTH, SLICE);
   end

   seq_add_state_t              state;
   seq_add_state_t              state_nxt;
   logic [NSLICE-1:0][SLICE-1:0] a_reg;
   logic [NSLICE-1:0][SLICE-1:0] b_reg;
   logic [NSLICE-1:0][SLICE-1:0] sum_reg;
   logic                        carry_reg;
   logic                        cout_reg;
   logic [IDX_W-1:0]            idx;

   logic [SLICE-1:0]            s0;
   logic [SLICE-1:0]            s1;
   logic                        c0;
   logic                        c1;
   logic [SLICE-1:0]            sel_sum;
   logic                        sel_carry;
   logic                        accept;
   logic                        last_step;

   cond_sum_slice #(
      .SLICE (SLICE)
   ) u_slice (
      .a  (a_reg[idx]),
      .b  (b_reg[idx]),
      .s0 (s0),
      .s1 (s1),
      .c0 (c0),
      .c1 (c1)
   );

   assign sel_sum   = carry_reg ? s1 : s0;
   assign sel_carry = carry_reg ? c1 : c0;
   assign accept    = (state == IDLE) && bus.in_valid;
   assign last_step = (state == RUN) && (idx == LAST_IDX);

   // State register; reset drops any operation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: accept in IDLE, step through every slice, hold DONE until taken.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (bus.in_valid)   state_nxt = RUN;
         RUN:     if (idx == LAST_IDX) state_nxt = DONE;
         DONE:    if (bus.out_ready)  state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // Datapath: latch operands on accept, then fold one selected slice per RUN cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg     <= '0;
         b_reg     <= '0;
         sum_reg   <= '0;
         carry_reg <= 1'b0;
         cout_reg  <= 1'b0;
         idx       <= '0;
      end else if (accept) begin
         a_reg     <= bus.a;
         b_reg     <= bus.b;
         carry_reg <= bus.cin;
         sum_reg   <= '0;
         idx       <= '0;
      end else if (state == RUN) begin
         sum_reg[idx] <= sel_sum;
         carry_reg    <= sel_carry;
         idx          <= idx + IDX_W'(1);
         if (last_step) begin
            cout_reg <= sel_carry;
         end
      end
   end

`ifdef SEQ_ADD_OVF_EN
   logic ovf_reg;

   // Signed overflow: like-signed operands whose final sum flips sign.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else if (last_step) begin
         ovf_reg <= (a_reg[NSLICE-1][SLICE-1] == b_reg[NSLICE-1][SLICE-1]) &&
                    (sel_sum[SLICE-1] != a_reg[NSLICE-1][SLICE-1]);
      end
   end

   assign bus.ovf = ovf_reg;
`endif

   assign bus.in_ready  = (state == IDLE);
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.sum       = sum_reg;
   assign bus.cout      = cout_reg;

endmodule
